control_sequencer: RTL and testbench
====================================

Name: control_sequencer

Overview:
- Hardwired control unit that drives the datapath's fetch/execute control strobes in place of a hand-written state sequence.
- Steps T0..T6 per instruction.
- Decodes the Ra/Rb/Rc fields of IR into one-hot register in/out enables.
- Handshakes instruction fetch with memory through mem_ready.

Parameters:
- OPW, 5, opcode field width (IR[31:27]).
- NREG, 16, number of general registers; register fields are log2(NREG)=4 bits.

Ports:
- Clock  in  1  system clock, rising-edge.
- clear  in  1  asynchronous, active-low reset.
- start  in  1  single-cycle pulse; begin executing from current PC.
- stop  in  1  level; halt after the current instruction completes.
- mem_ready  in  1  memory data valid on Mdatain this cycle.
- IR  in  32  current instruction register contents from datapath.
- Rin  out  16  one-hot general register load enables (R0in..R15in).
- Rout  out  16  one-hot general register bus drivers (R0out..R15out).
- PCout, MARin, IncPC, Zin, Zlowout, Zhighout, PCin, Read, MDRin, MDRout, IRin, Yin, HIin, LOin  out  1 each  datapath strobes.
- opcode  out  5  ALU operation select.
- run  out  1  high while sequencing.
- done  out  1  one-cycle pulse at the last step of each instruction.
- fault  out  1  sticky; illegal opcode seen.

Behaviour:
- IR fields: op=IR[31:27], Ra=IR[26:23], Rb=IR[22:19], Rc=IR[18:15].
- Supported ops: add 00011, sub 00100, and 00101, or 00110, shr 00111, ror 01000, shl 01001, rol 01010, mul 01111, div 10000, halt 11011.
- clear low (async): state=IDLE. All outputs 0, including fault, run and opcode.
- Outputs are decoded combinationally from the registered state plus IR; no strobe asserts outside its listed state.
- IDLE: all strobes 0. start=1 -> T0. start while not in IDLE is ignored.
- T0: PCout, MARin, IncPC, Zin. -> T1.
- T1: Zlowout, PCin, Read, MDRin, held every cycle. Stay in T1 while mem_ready=0; -> T2 when mem_ready=1. Repeated PCin is idempotent because Z is unchanged.
- T2: MDRout, IRin. -> T3. IR is valid from T3 onward.
- T3: decode op.
  - Illegal op: fault=1 -> FAULT.
  - halt: done=1 -> IDLE.
  - Otherwise Rout[Rb]=1, Yin. -> T4.
- T4: Rout[Rc]=1, opcode=op, Zin. -> T5.
- T5:
  - ALU ops: Zlowout, Rin[Ra]=1, done=1. -> next.
  - mul/div: Zlowout, LOin. -> T6.
- T6 (mul/div only): Zhighout, HIin, done=1. -> next.
- next: if stop=1 or fault=1 -> IDLE, else -> T0.
- FAULT: all strobes 0, run=0. Exit only by clear.
- run=1 in every state except IDLE and FAULT.
- opcode output holds op during T4 only; it is 0 elsewhere.
- Latency: ALU instruction is 6 cycles + fetch wait cycles; mul/div is 7. Back-to-back instructions have no bubble.
- Ra=Rb=Rc is legal. Rin/Rout remain one-hot, and Rin and Rout are never asserted in the same cycle.
- Reset mid-instruction: outputs drop asynchronously. No partial write-back, because Rin is asserted only in T5.
- stop asserted during T0..T4 takes effect at the end of that instruction. stop asserted in IDLE has no effect.

Decomposition:
- Shared package control_defs:
  - opcode localparams;
  - state encoding (IDLE, T0..T6, FAULT; 4-bit);
  - IR field bit positions.
- Sub-module reg_select_decoder: 4-to-16 one-hot with enable, instantiated twice (Rin from Ra, Rout from Rb/Rc mux by state).

Test Plan:
- Reset, then start; IR=0x18918000 (add R1,R2,R3); mem_ready tied 1; R2=5, R3=8 preloaded.
  -> T0..T5 in 6 cycles.
  -> Rout=0x0004 at T3, Rout=0x0008 and opcode=00011 at T4, Rin=0x0002 at T5, done pulse; R1=13.
- ror with IR op=01000, mem_ready delayed 3 cycles.
  -> T1 held 4 cycles with Read=1 throughout; instruction takes 9 cycles; opcode=01000 only in T4.
- mul (op 01111).
  -> LOin at T5, HIin at T6, no Rin asserted at any step, done at T6.
- Illegal op 11111.
  -> fault=1 after T3, run=0, no Yin/Zin after T2; start ignored until clear is asserted low.
- stop raised during T4 of first instruction.
  -> instruction completes (Rin at T5), then IDLE; no T0 follows.
- clear pulled low during T4.
  -> all outputs 0 immediately; after release, IDLE until the next start.

Source files
------------

// File: rtl/control_sequencer_pkg.sv
// Shared definitions for the hardwired control sequencer: opcodes, step
// encoding and instruction-register field positions.
package control_defs;

  localparam int OPW  = 5;
  localparam int NREG = 16;
  localparam int RSW  = 4;

  localparam logic [OPW-1:0] OP_ADD  = 5'b00011;
  localparam logic [OPW-1:0] OP_SUB  = 5'b00100;
  localparam logic [OPW-1:0] OP_AND  = 5'b00101;
  localparam logic [OPW-1:0] OP_OR   = 5'b00110;
  localparam logic [OPW-1:0] OP_SHR  = 5'b00111;
  localparam logic [OPW-1:0] OP_ROR  = 5'b01000;
  localparam logic [OPW-1:0] OP_SHL  = 5'b01001;
  localparam logic [OPW-1:0] OP_ROL  = 5'b01010;
  localparam logic [OPW-1:0] OP_MUL  = 5'b01111;
  localparam logic [OPW-1:0] OP_DIV  = 5'b10000;
  localparam logic [OPW-1:0] OP_HALT = 5'b11011;

  localparam int OP_MSB = 31;
  localparam int OP_LSB = 27;
  localparam int RA_MSB = 26;
  localparam int RA_LSB = 23;
  localparam int RB_MSB = 22;
  localparam int RB_LSB = 19;
  localparam int RC_MSB = 18;
  localparam int RC_LSB = 15;

  typedef enum logic [3:0] {
    S_IDLE  = 4'd0,
    S_T0    = 4'd1,
    S_T1    = 4'd2,
    S_T2    = 4'd3,
    S_T3    = 4'd4,
    S_T4    = 4'd5,
    S_T5    = 4'd6,
    S_T6    = 4'd7,
    S_FAULT = 4'd8
  } state_t;

  function automatic logic is_legal(input logic [OPW-1:0] op);
    case (op)
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SHR, OP_ROR,
      OP_SHL, OP_ROL, OP_MUL, OP_DIV, OP_HALT: is_legal = 1'b1;
      default:                                 is_legal = 1'b0;
    endcase
  endfunction

  function automatic logic is_muldiv(input logic [OPW-1:0] op);
    is_muldiv = (op == OP_MUL) || (op == OP_DIV);
  endfunction

endpackage

// File: rtl/control_sequencer_if.sv
// Control bus between the sequencer (master) and the datapath (slave):
// instruction/handshake inputs plus all register enables and strobes.
interface control_sequencer_if;
  import control_defs::*;

  logic            start;
  logic            stop;
  logic            mem_ready;
  logic [31:0]     IR;
  logic [NREG-1:0] Rin;
  logic [NREG-1:0] Rout;
  logic            PCout, MARin, IncPC, Zin, Zlowout, Zhighout, PCin;
  logic            Read, MDRin, MDRout, IRin, Yin, HIin, LOin;
  logic [OPW-1:0]  opcode;
  logic            run;
  logic            done;
  logic            fault;

  modport master (
    input  start, stop, mem_ready, IR,
    output Rin, Rout, PCout, MARin, IncPC, Zin, Zlowout, Zhighout, PCin,
           Read, MDRin, MDRout, IRin, Yin, HIin, LOin, opcode, run, done, fault
  );

  modport slave (
    output start, stop, mem_ready, IR,
    input  Rin, Rout, PCout, MARin, IncPC, Zin, Zlowout, Zhighout, PCin,
           Read, MDRin, MDRout, IRin, Yin, HIin, LOin, opcode, run, done, fault
  );

endinterface

// File: rtl/control_sequencer_reg_select_decoder.sv
// 4-to-16 one-hot register select decoder with enable; all-zero when disabled.
module reg_select_decoder
  import control_defs::*;
(
  input  logic [RSW-1:0]  sel,
  input  logic            en,
  output logic [NREG-1:0] onehot
);

  always_comb begin
    onehot = '0;
    if (en) onehot[sel] = 1'b1;
  end

endmodule

// File: rtl/control_sequencer.sv
// Hardwired fetch/execute sequencer: steps T0..T6 per instruction, with the
// datapath strobes decoded from the registered step and the current IR.
module control_sequencer
  import control_defs::*;
(
  input  logic                Clock,
  input  logic                clear,
  control_sequencer_if.master bus
);

  state_t         state;
  logic           stop_pending;
  logic [OPW-1:0] op;
  logic [RSW-1:0] ra, rb, rc;
  logic           legal, muldiv, finish_req;
  logic           rin_en, rout_en;
  logic [RSW-1:0] rout_sel;
  logic [NREG-1:0] rin_onehot, rout_onehot;
  logic           ir_unused;

  assign op        = bus.IR[OP_MSB:OP_LSB];
  assign ra        = bus.IR[RA_MSB:RA_LSB];
  assign rb        = bus.IR[RB_MSB:RB_LSB];
  assign rc        = bus.IR[RC_MSB:RC_LSB];
  assign ir_unused = ^bus.IR[RC_LSB-1:0];
  assign legal     = is_legal(op);
  assign muldiv    = is_muldiv(op);
  assign finish_req = bus.stop | stop_pending;

  // A stop seen at any step of a running instruction is remembered so that
  // even a short stop pulse halts the sequence at the instruction's last step.
  always_ff @(posedge Clock or negedge clear) begin
    if (!clear)                                   stop_pending <= 1'b0;
    else if (state == S_IDLE || state == S_FAULT) stop_pending <= 1'b0;
    else if (bus.stop)                            stop_pending <= 1'b1;
  end

  always_ff @(posedge Clock or negedge clear) begin
    if (!clear) begin
      state <= S_IDLE;
    end else begin
      case (state)
        S_IDLE:  if (bus.start) state <= S_T0;
        S_T0:    state <= S_T1;
        S_T1:    if (bus.mem_ready) state <= S_T2;
        S_T2:    state <= S_T3;
        S_T3: begin
          if (!legal)              state <= S_FAULT;
          else if (op == OP_HALT)  state <= S_IDLE;
          else                     state <= S_T4;
        end
        S_T4:    state <= S_T5;
        S_T5: begin
          if (muldiv)          state <= S_T6;
          else if (finish_req) state <= S_IDLE;
          else                 state <= S_T0;
        end
        S_T6:    state <= finish_req ? S_IDLE : S_T0;
        S_FAULT: state <= S_FAULT;
        default: state <= S_IDLE;
      endcase
    end
  end

  // Register bus drivers read Rb at T3 and Rc at T4; load enables write Ra
  // only at T5 of ALU ops, so Rin and Rout can never overlap.
  assign rout_sel = (state == S_T3) ? rb : rc;
  assign rout_en  = ((state == S_T3) && legal && (op != OP_HALT)) || (state == S_T4);
  assign rin_en   = (state == S_T5) && !muldiv;

  reg_select_decoder u_rin_dec (
    .sel    (ra),
    .en     (rin_en),
    .onehot (rin_onehot)
  );

  reg_select_decoder u_rout_dec (
    .sel    (rout_sel),
    .en     (rout_en),
    .onehot (rout_onehot)
  );

  assign bus.Rin  = rin_onehot;
  assign bus.Rout = rout_onehot;

  always_comb begin
    bus.PCout    = 1'b0;
    bus.MARin    = 1'b0;
    bus.IncPC    = 1'b0;
    bus.Zin      = 1'b0;
    bus.Zlowout  = 1'b0;
    bus.Zhighout = 1'b0;
    bus.PCin     = 1'b0;
    bus.Read     = 1'b0;
    bus.MDRin    = 1'b0;
    bus.MDRout   = 1'b0;
    bus.IRin     = 1'b0;
    bus.Yin      = 1'b0;
    bus.HIin     = 1'b0;
    bus.LOin     = 1'b0;
    bus.opcode   = '0;
    bus.done     = 1'b0;
    bus.fault    = 1'b0;
    bus.run      = (state != S_IDLE) && (state != S_FAULT);
    case (state)
      S_T0: begin
        bus.PCout = 1'b1;
        bus.MARin = 1'b1;
        bus.IncPC = 1'b1;
        bus.Zin   = 1'b1;
      end
      S_T1: begin
        bus.Zlowout = 1'b1;
        bus.PCin    = 1'b1;
        bus.Read    = 1'b1;
        bus.MDRin   = 1'b1;
      end
      S_T2: begin
        bus.MDRout = 1'b1;
        bus.IRin   = 1'b1;
      end
      S_T3: begin
        if (!legal)             bus.fault = 1'b1;
        else if (op == OP_HALT) bus.done  = 1'b1;
        else                    bus.Yin   = 1'b1;
      end
      S_T4: begin
        bus.opcode = op;
        bus.Zin    = 1'b1;
      end
      S_T5: begin
        bus.Zlowout = 1'b1;
        if (muldiv) bus.LOin = 1'b1;
        else        bus.done = 1'b1;
      end
      S_T6: begin
        bus.Zhighout = 1'b1;
        bus.HIin     = 1'b1;
        bus.done     = 1'b1;
      end
      S_FAULT: bus.fault = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_control_sequencer.sv
// Self-checking bench: per-instruction expected strobe sequences built from
// the instruction class, compared cycle by cycle, plus a tiny register file.
module tb_control_sequencer;
  import control_defs::*;

  typedef struct packed {
    logic [15:0] rin;
    logic [15:0] rout;
    logic pcout, marin, incpc, zin, zlowout, zhighout, pcin;
    logic read, mdrin, mdrout, irin, yin, hiin, loin;
    logic [4:0] opcode;
    logic run, done, fault;
  } outs_t;

  logic Clock;
  logic clear;
  int   checks;
  int   passes;
  outs_t exp_q[$];

  logic [31:0] regs [16];
  logic [31:0] y_reg, z_reg;
  logic        preload;

  logic [4:0] legal_ops [11] = '{OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SHR, OP_ROR,
                                 OP_SHL, OP_ROL, OP_MUL, OP_DIV, OP_HALT};

  control_sequencer_if cs();

  control_sequencer dut (
    .Clock (Clock),
    .clear (clear),
    .bus   (cs)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  // Minimal datapath: registers drive a shared bus, Y/Z latch, add computes.
  function automatic logic [31:0] bus_val();
    logic [31:0] v;
    v = '0;
    for (int i = 0; i < 16; i++) if (cs.Rout[i]) v = v | regs[i];
    return v;
  endfunction

  always @(posedge Clock) begin
    if (preload) begin
      for (int i = 0; i < 16; i++) regs[i] <= (i == 2) ? 32'd5 : (i == 3) ? 32'd8 : 32'd0;
    end else begin
      if (cs.Yin) y_reg <= bus_val();
      if (cs.Zin && cs.opcode == OP_ADD) z_reg <= y_reg + bus_val();
      if (cs.Zlowout)
        for (int i = 0; i < 16; i++) if (cs.Rin[i]) regs[i] <= z_reg;
    end
  end

  function automatic outs_t sample();
    outs_t s;
    s.rin = cs.Rin;        s.rout = cs.Rout;
    s.pcout = cs.PCout;    s.marin = cs.MARin;     s.incpc = cs.IncPC;
    s.zin = cs.Zin;        s.zlowout = cs.Zlowout; s.zhighout = cs.Zhighout;
    s.pcin = cs.PCin;      s.read = cs.Read;       s.mdrin = cs.MDRin;
    s.mdrout = cs.MDRout;  s.irin = cs.IRin;       s.yin = cs.Yin;
    s.hiin = cs.HIin;      s.loin = cs.LOin;       s.opcode = cs.opcode;
    s.run = cs.run;        s.done = cs.done;       s.fault = cs.fault;
    return s;
  endfunction

  function automatic logic model_legal(input logic [4:0] op);
    for (int i = 0; i < 11; i++) if (legal_ops[i] == op) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [31:0] mkir(input logic [4:0] op, input logic [3:0] ra,
                                       input logic [3:0] rb, input logic [3:0] rc);
    return {op, ra, rb, rc, 15'd0};
  endfunction

  // Expected per-cycle outputs of one instruction, starting at its first step.
  task automatic build(input logic [4:0] op, input logic [3:0] ra, input logic [3:0] rb,
                       input logic [3:0] rc, input int waits);
    outs_t s;
    exp_q.delete();
    s = '0; s.run = 1; s.pcout = 1; s.marin = 1; s.incpc = 1; s.zin = 1;
    exp_q.push_back(s);
    for (int w = 0; w <= waits; w++) begin
      s = '0; s.run = 1; s.zlowout = 1; s.pcin = 1; s.read = 1; s.mdrin = 1;
      exp_q.push_back(s);
    end
    s = '0; s.run = 1; s.mdrout = 1; s.irin = 1;
    exp_q.push_back(s);
    s = '0; s.run = 1;
    if (!model_legal(op)) begin
      s.fault = 1; exp_q.push_back(s); return;
    end
    if (op == OP_HALT) begin
      s.done = 1; exp_q.push_back(s); return;
    end
    s.rout = 16'd1 << rb; s.yin = 1;
    exp_q.push_back(s);
    s = '0; s.run = 1; s.rout = 16'd1 << rc; s.opcode = op; s.zin = 1;
    exp_q.push_back(s);
    s = '0; s.run = 1; s.zlowout = 1;
    if (op == OP_MUL || op == OP_DIV) begin
      s.loin = 1; exp_q.push_back(s);
      s = '0; s.run = 1; s.zhighout = 1; s.hiin = 1; s.done = 1;
      exp_q.push_back(s);
    end else begin
      s.rin = 16'd1 << ra; s.done = 1; exp_q.push_back(s);
    end
  endtask

  // Called at the falling edge of the instruction's T0; returns one cycle
  // after its last step. stop_step < 0 leaves stop alone.
  task automatic exec(input string name, input logic [4:0] op, input logic [3:0] ra,
                      input logic [3:0] rb, input logic [3:0] rc, input int waits,
                      input int stop_step);
    outs_t act;
    build(op, ra, rb, rc, waits);
    cs.IR = mkir(op, ra, rb, rc);
    for (int k = 0; k < exp_q.size(); k++) begin
      act = sample();
      checks++;
      if (act !== exp_q[k])
        $display("[TB] FAIL %s step %0d: got %h expected %h", name, k, act, exp_q[k]);
      else
        passes++;
      cs.mem_ready = (k >= waits + 1);
      if (k == stop_step) cs.stop = 1'b1;
      @(negedge Clock);
    end
    cs.mem_ready = 1'b0;
  endtask

  task automatic check_idle(input string name, input int cycles);
    outs_t act;
    for (int i = 0; i < cycles; i++) begin
      act = sample();
      checks++;
      if (act !== outs_t'('0))
        $display("[TB] FAIL %s cycle %0d: got %h expected 0", name, i, act);
      else
        passes++;
      @(negedge Clock);
    end
  endtask

  task automatic pulse_start();
    cs.start = 1'b1;
    @(negedge Clock);
    cs.start = 1'b0;
  endtask

  task automatic test_reset();
    outs_t act;
    clear = 1'b0;
    #3;
    act = sample();
    checks++;
    if (act !== outs_t'('0)) $display("[TB] FAIL reset_outputs: got %h expected 0", act);
    else passes++;
    @(negedge Clock);
    clear = 1'b1;
    cs.stop = 1'b1;
    check_idle("idle_after_reset", 3);
    cs.stop = 1'b0;
  endtask

  task automatic test_add();
    preload = 1'b1;
    @(negedge Clock);
    preload = 1'b0;
    cs.IR = 32'h18918000;
    pulse_start();
    exec("add", OP_ADD, 4'd1, 4'd2, 4'd3, 0, 0);
    cs.stop = 1'b0;
    check_idle("add_idle", 2);
    checks++;
    if (regs[1] !== 32'd13) $display("[TB] FAIL add_writeback: got %0d expected 13", regs[1]);
    else passes++;
  endtask

  task automatic test_ror_wait();
    pulse_start();
    exec("ror_wait", OP_ROR, 4'd4, 4'd5, 4'd6, 3, 2);
    cs.stop = 1'b0;
    check_idle("ror_idle", 2);
  endtask

  task automatic test_muldiv();
    pulse_start();
    exec("mul", OP_MUL, 4'd7, 4'd8, 4'd9, $urandom_range(0, 2), -1);
    exec("div", OP_DIV, 4'd2, 4'd2, 4'd2, 0, 4);
    cs.stop = 1'b0;
    check_idle("muldiv_idle", 2);
  endtask

  task automatic test_halt();
    pulse_start();
    exec("halt", OP_HALT, 4'd0, 4'd0, 4'd0, 1, -1);
    check_idle("halt_idle", 3);
  endtask

  task automatic test_back_to_back();
    logic [4:0] op;
    int n;
    pulse_start();
    n = 8;
    for (int i = 0; i < n; i++) begin
      op = legal_ops[$urandom_range(0, 9)];
      exec("b2b", op, 4'($urandom), 4'($urandom), 4'($urandom), $urandom_range(0, 3),
           (i == n - 1) ? 1 : -1);
    end
    cs.stop = 1'b0;
    check_idle("b2b_idle", 2);
  endtask

  task automatic test_stop_t4();
    pulse_start();
    exec("stop_t4", OP_SUB, 4'd3, 4'd1, 4'd2, 0, 4);
    @(posedge Clock);
    cs.stop = 1'b0;
    @(negedge Clock);
    check_idle("stop_no_t0", 3);
  endtask

  task automatic test_illegal();
    outs_t act, want;
    pulse_start();
    exec("illegal", 5'b11111, 4'd1, 4'd1, 4'd1, 0, -1);
    want = '0;
    want.fault = 1'b1;
    for (int i = 0; i < 4; i++) begin
      cs.start = (i % 2 == 0);
      act = sample();
      checks++;
      if (act !== want) $display("[TB] FAIL fault_hold cycle %0d: got %h expected %h", i, act, want);
      else passes++;
      @(negedge Clock);
    end
    cs.start = 1'b0;
    clear = 1'b0;
    #1;
    act = sample();
    checks++;
    if (act !== outs_t'('0)) $display("[TB] FAIL fault_clear: got %h expected 0", act);
    else passes++;
    @(negedge Clock);
    clear = 1'b1;
    check_idle("after_fault_clear", 2);
  endtask

  task automatic test_clear_mid();
    logic [31:0] r1_before;
    outs_t act;
    r1_before = regs[1];
    cs.IR = mkir(OP_ADD, 4'd1, 4'd2, 4'd3);
    pulse_start();
    cs.mem_ready = 1'b1;
    repeat (4) @(negedge Clock);
    checks++;
    if (cs.Rout !== 16'h0008 || cs.opcode !== OP_ADD)
      $display("[TB] FAIL clear_mid_t4: got Rout %h opcode %b expected 0008 00011", cs.Rout, cs.opcode);
    else passes++;
    clear = 1'b0;
    #1;
    act = sample();
    checks++;
    if (act !== outs_t'('0)) $display("[TB] FAIL clear_mid_async: got %h expected 0", act);
    else passes++;
    @(negedge Clock);
    clear = 1'b1;
    check_idle("clear_mid_idle", 3);
    cs.mem_ready = 1'b0;
    checks++;
    if (regs[1] !== r1_before) $display("[TB] FAIL clear_mid_no_writeback: got %0d expected %0d", regs[1], r1_before);
    else passes++;
  endtask

  initial begin
    checks = 0;
    passes = 0;
    preload = 1'b0;
    clear = 1'b0;
    cs.start = 1'b0;
    cs.stop = 1'b0;
    cs.mem_ready = 1'b0;
    cs.IR = '0;
    test_reset();
    test_add();
    test_ror_wait();
    test_muldiv();
    test_halt();
    test_back_to_back();
    test_stop_t4();
    test_clear_mid();
    test_illegal();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
